// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x oversampling 8N1 UART receiver.
// Each good byte appears on data together with a one-cycle valid strobe.
// A low stop bit gives a one-cycle frame_err strobe, and the byte is dropped.
// Build option UART_RX_MAJORITY_EN: each bit decision becomes the 2-of-3 majority
// of the samples at smp 7, 8 and 9. Without it, the sample at smp 8 alone decides.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | validating the start bit
// DATA   | shifting in data bits 1..8
// STOP   | checking the stop bit
// BREAK  | stop bit was low; wait for the line to return high
module uart_rx_os16 #(
    parameter int unsigned DIV = 27
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       active
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    logic        rx_meta_q;
    logic        rx_s_q;
    state_t      state_q, state_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [3:0]  smp_q, smp_d;
    logic [3:0]  bitn_q, bitn_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        s8_q, s8_d;
    logic        tick;
    logic        decide;
    logic        wrap;
    logic        bit_val;

    assign tick   = (div_cnt_q == DIV_LAST);
    assign decide = tick && (smp_q == 4'd9);
    assign wrap   = tick && (smp_q == 4'd15);

`ifdef UART_RX_MAJORITY_EN
    logic s7_q, s7_d;

    // Hold the smp 7 sample for the majority vote.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) s7_q <= 1'b0;
        else       s7_q <= s7_d;
    end

    assign s7_d    = (tick && smp_q == 4'd7) ? rx_s_q : s7_q;
    // The smp 9 sample is rx_s itself on the decision tick.
    assign bit_val = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
`else
    assign bit_val = s8_q;
`endif

    // Two-flop synchroniser; idles high so that reset does not look like a start bit.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            smp_q     <= '0;
            bitn_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            s8_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            smp_q     <= smp_d;
            bitn_q    <= bitn_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            s8_q      <= s8_d;
        end
    end

    // Next-state logic: sample tracking, bit decisions and strobes.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
        smp_d     = tick ? smp_q + 4'd1 : smp_q;
        bitn_d    = bitn_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        s8_d      = (tick && smp_q == 4'd8) ? rx_s_q : s8_q;

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d   = S_START;
                    div_cnt_d = 16'd0;
                    smp_d     = 4'd0;
                    bitn_d    = 4'd0;
                end
            end
            S_START: begin
                if (decide && bit_val) begin
                    state_d = S_IDLE;
                end else if (wrap) begin
                    bitn_d  = 4'd1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {bit_val, shift_q[7:1]};
                end
                if (wrap) begin
                    bitn_d = bitn_q + 4'd1;
                    if (bitn_q == 4'd8) state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Leave straight after the decision so that the next start edge,
                // only half a bit away, is still caught.
                if (decide) begin
                    if (bit_val) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign active    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Testbench for uart_rx_os16 with DIV = 4, which gives 64 clocks per bit.
// The stimulus process pushes the expected frame outcome into a queue.
// A monitor on the falling edge pops one entry for every strobe and checks it.
module tb_uart_rx_os16;

    localparam int DIV = 4;
    localparam int BPER = 16 * DIV;

    typedef struct {
        logic       is_err;
        logic [7:0] b;
        int         e0;     // first edge that samples the start bit; -1 = no latency check
    } exp_t;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       active;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t expq[$];
    logic [7:0] last_good = 8'h00;
    logic prev_valid = 1'b0;
    logic prev_ferr = 1'b0;

    uart_rx_os16 #(.DIV(DIV)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .active    (active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (nRst) begin
            if (valid || frame_err) begin
                exp_t e;
                check("strobe_exclusive", int'(valid && frame_err), 0);
                check("strobe_width", int'((valid && prev_valid) || (frame_err && prev_ferr)), 0);
                if (expq.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("strobe_kind_ferr", int'(frame_err), int'(e.is_err));
                    if (e.is_err) begin
                        check("data_held_on_ferr", int'(data), int'(last_good));
                    end else begin
                        check("rx_data", int'(data), int'(e.b));
                        last_good = e.b;
                    end
                    if (e.e0 >= 0) check("latency_from_e0", cyc - e.e0, 154 * DIV + 2);
                end
            end
            prev_valid = valid;
            prev_ferr  = frame_err;
        end else begin
            prev_valid = 1'b0;
            prev_ferr  = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rx = 1'b1;
        end
    endtask

    // Drive one 10-bit frame at bper clocks per bit. glitch_i inverts one clock,
    // and rst_at pulses reset at that clock and abandons the frame.
    task automatic send_frame(input logic [7:0] b, input int bper, input logic stop_v,
                              input int glitch_i, input int rst_at, input logic lat_chk);
        logic [9:0] bits;
        exp_t e;
        int   e0;
        bits = {stop_v, b, 1'b0};
        @(posedge clk); #1;
        e0 = cyc + 1;
        if (rst_at < 0) begin
            e.is_err = ~stop_v;
            e.b      = b;
            e.e0     = lat_chk ? e0 : -1;
            expq.push_back(e);
        end
        for (int i = 0; i < 10 * bper; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (i == rst_at) begin
                nRst = 1'b0;
                rx   = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                check("rst_data", int'(data), 0);
                check("rst_valid", int'(valid), 0);
                check("rst_ferr", int'(frame_err), 0);
                check("rst_active", int'(active), 0);
                last_good = 8'h00;
                nRst = 1'b1;
                return;
            end
            rx = bits[i / bper] ^ (i == glitch_i);
        end
    endtask

    initial begin
        int seen;
        // Reset state.
        repeat (4) @(posedge clk);
        #1;
        check("reset_data", int'(data), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_ferr", int'(frame_err), 0);
        check("reset_active", int'(active), 0);
        nRst = 1'b1;
        idle(10);

        // Good byte with the exact latency check.
        send_frame(8'hA5, BPER, 1'b1, -1, -1, 1'b1);
        idle(30);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, BPER, 1'b1, -1, -1, 1'b0);
        send_frame(8'hFF, BPER, 1'b1, -1, -1, 1'b0);
        send_frame(8'h3C, BPER, 1'b1, -1, -1, 1'b0);
        idle(30);

        // Stop bit low, then a break on the line.
        send_frame(8'h55, BPER, 1'b0, -1, -1, 1'b0);
        repeat (200) begin
            @(posedge clk); #1;
            rx = 1'b0;
        end
        check("active_during_break", int'(active), 1);
        idle(6);
        check("active_after_break", int'(active), 0);
        idle(20);

        // One-clock low glitch while idle.
        @(posedge clk); #1;
        rx = 1'b0;
        @(posedge clk); #1;
        rx = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (active) seen = 1;
        end
        check("glitch_active_pulse", seen, 1);
        idle(100);
        check("glitch_back_to_idle", int'(active), 0);

`ifdef UART_RX_MAJORITY_EN
        // Inverted sample at smp 8 of data bit 3 is outvoted.
        send_frame(8'h00, BPER, 1'b1, 4 * BPER + 36, -1, 1'b0);
        idle(20);
`endif

        // Reset during data bit 4 of 0x81, then a clean byte.
        send_frame(8'h81, BPER, 1'b1, -1, 5 * BPER + 32, 1'b0);
        idle(20);
        send_frame(8'h42, BPER, 1'b1, -1, -1, 1'b0);
        idle(20);

        // Baud skew at both ends of the tolerance window.
        send_frame(8'h96, 62, 1'b1, -1, -1, 1'b0);
        idle(20);
        send_frame(8'h96, 66, 1'b1, -1, -1, 1'b0);
        idle(20);

        // Random bytes, baud rates and gaps.
        for (int k = 0; k < 8; k++) begin
            send_frame(8'($urandom), int'($urandom_range(62, 66)), 1'b1, -1, -1, 1'b0);
            idle(int'($urandom_range(0, 20)));
        end

        for (int i = 0; i < 2000 && expq.size() != 0; i++) @(posedge clk);
        idle(20);
        check("all_expected_strobes_seen", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
